pos_core_nd: RTL and testbench
==============================

# pos_core_nd

Parametrised successor to the two-axis position-sum stage in the KNN datapath. It splits each incoming label into `DIMS` equal coordinate fields and adds each field to a running per-dimension sum. It runs in one of two modes: chain mode adds to the sums passed in from the previous stage, and accumulate mode adds to its own internal accumulator over a burst of labels. It adds valid/last handshaking, an overflow flag and optional saturation.

## Interface
- `LBL_LEN`, 10: label width. Must be divisible by `DIMS`.
- `DIMS`, 2: number of coordinate fields (channels).
- `CSUM_LEN`, 7: width of each per-dimension sum.
- `clk` in 1: clock. All logic on posedge.
- `rst` in 1: reset, synchronous and active-high.
- `inValid` in 1: the input beat is valid this cycle.
- `inL` in `LBL_LEN`: label. Field 0 is the MSB field, bits [LBL_LEN-1 : LBL_LEN-FIELD_LEN].
- `inPrev` in `DIMS*CSUM_LEN`: previous sums. Dimension d occupies bits [(DIMS-d)*CSUM_LEN-1 -: CSUM_LEN].
- `inMode` in 1: 0 = chain, 1 = accumulate. Sampled only when `inValid` is high.
- `inLast` in 1: last beat of an accumulate burst. Ignored in chain mode.
- `outValid` out 1: one-cycle pulse when `outSum` carries a new result.
- `outSum` out `DIMS*CSUM_LEN`: result sums, packed the same way as `inPrev`.
- `outOvf` out 1: the result on `outSum` overflowed in at least one dimension.

## Operation
- `FIELD_LEN = LBL_LEN/DIMS`. Each field is zero-extended before it is added.
- Each dimension's add is `CSUM_LEN+1` bits wide. The carry-out is that dimension's overflow.
- Chain beat (`inValid`=1, `inMode`=0):
  - `outSum[d] <= inPrev[d] + field[d]`.
  - `outOvf <=` OR of the carries from all dimensions.
  - `outValid <= 1`.
- Accumulate mode uses a two-state FSM, IDLE and ACC, with an internal accumulator `acc[DIMS]` and a sticky flag `accOvf`.
  - IDLE, accumulate beat: `acc <= inPrev + field`, which seeds the accumulator from `inPrev`. `accOvf <=` carry. If `inLast`=0, go to ACC.
  - ACC, accumulate beat: `acc <= acc + field`. `accOvf <= accOvf | carry`.
  - A beat with `inLast`=1, in either state:
    - `outSum <=` the updated sums and `outOvf <=` the updated `accOvf`.
    - `outValid <= 1`.
    - Go to IDLE and clear `acc` and `accOvf`.
  - A single beat with `inLast`=1 received in IDLE is a complete one-beat burst.
- Chain beat during ACC: handled as a normal chain beat. `acc`, `accOvf` and the state are untouched, and the burst continues afterwards.
- `inValid`=0: `outValid <= 0`. `outSum`, `outOvf`, `acc` and the state all hold.
- Reset: `outSum`=0, `outOvf`=0, `outValid`=0, state=IDLE, `acc`=0, `accOvf`=0. Reset in the middle of a burst discards the partial burst and produces no output.
- Reset takes priority over a valid beat arriving in the same cycle.

## Timing
- Latency is 1 cycle from the input beat to `outValid`/`outSum`, in both modes. All outputs come directly from registers.
- Throughput is one beat per cycle with no backpressure. The consumer must accept every `outValid` pulse.
- In accumulate mode, `outValid` pulses exactly once per burst, in the cycle after the `inLast` beat. It does not pulse for intermediate beats.
- There are no combinational paths from input to output.

## Configuration
- `POS_CORE_SAT_EN` defined: any dimension that carries out clamps to 2^CSUM_LEN-1. This applies in both modes, including intermediate `acc` values.
- `POS_CORE_SAT_EN` undefined: sums wrap modulo 2^CSUM_LEN.
- `outOvf`/`accOvf` are set the same way in both builds.

## Structure
- Shared package `pos_pkg` holds:
  - mode constants `POS_MODE_CHAIN`=0 and `POS_MODE_ACC`=1;
  - the FSM state enum (IDLE, ACC);
  - a function that extracts field d from a label.
- Sub-module `pos_lane` is one dimension's `CSUM_LEN+1`-bit adder plus the saturate/wrap logic, with outputs sum and carry. It is instantiated `DIMS` times in a generate loop.
- The FSM, the valid/last handling and the overflow OR live in `pos_core_nd`.

## Test plan
All scenarios use the defaults (fields are 5 bits).
- Chain beat: `inL`=10'b00011_00101, prev (10,20) -> next cycle `outValid`=1, `outSum`=(13,25), `outOvf`=0.
- Overflow: chain beat with prev (120,0), field (31,0) -> `outSum` x=23 and `outOvf`=1 without the macro; x=127 and `outOvf`=1 with `POS_CORE_SAT_EN`.
- Accumulate burst: prev (0,0), labels (1,2), (3,4), then (5,6) with `inLast` -> `outValid` only in the cycle after the third beat, `outSum`=(9,12).
- Chain beat inside a burst: burst (1,1), then chain beat prev (7,7) field (2,2), then (1,1) with `inLast` -> chain result (9,9) appears, then burst result (2,2).
- Reset mid-burst: two accumulate beats of (4,4), then `rst`, then a single (1,1) with `inLast`, prev 0 -> `outSum`=(1,1). No output is produced for the aborted burst.
- Bubbles: `inValid` low for 3 cycles between beats -> `outValid` stays 0 and `outSum` holds its last value.

Source files
------------

// File: rtl/pos_pkg.sv
// pos_pkg: definitions shared by the position-sum core and its lanes.
//   POS_MODE_CHAIN / POS_MODE_ACC : values of the inMode port.
//   pos_state_e                   : accumulate-burst FSM states.
//   pos_field()                   : extracts coordinate field d from a label.
//                                   Field 0 is the MSB field.
package pos_pkg;

  localparam logic POS_MODE_CHAIN = 1'b0;
  localparam logic POS_MODE_ACC   = 1'b1;

  // Widest label pos_field() can handle.
  localparam int unsigned POS_MAX_W = 64;

  typedef enum logic {
    POS_IDLE,
    POS_ACC
  } pos_state_e;

  // Returns field d of lbl, right-aligned and zero-extended.
  function automatic logic [POS_MAX_W-1:0] pos_field(
    input logic [POS_MAX_W-1:0] lbl,
    input int unsigned          lbl_len,
    input int unsigned          field_len,
    input int unsigned          d
  );
    int unsigned sh;
    sh = lbl_len - (d + 1) * field_len;
    return (lbl >> sh) & ~({POS_MAX_W{1'b1}} << field_len);
  endfunction

endpackage

// File: rtl/pos_lane.sv
// pos_lane: one dimension of the position-sum datapath.
// Adds a zero-extended coordinate field to a CSUM_LEN-bit base in a
// CSUM_LEN+1-bit adder; the carry-out is this lane's overflow.
// Build option: POS_CORE_SAT_EN defined -> an overflowing sum clamps to
// all-ones; undefined -> the sum wraps modulo 2^CSUM_LEN.
// Ports:
//   base_i  [CSUM_LEN]  : running sum (previous-stage sum or accumulator)
//   field_i [FIELD_LEN] : coordinate field from the label
//   sum_o   [CSUM_LEN]  : wrapped or saturated result
//   carry_o             : carry-out of the widened add
module pos_lane #(
  parameter int unsigned CSUM_LEN  = 7,
  parameter int unsigned FIELD_LEN = 5
) (
  input  logic [CSUM_LEN-1:0]  base_i,
  input  logic [FIELD_LEN-1:0] field_i,
  output logic [CSUM_LEN-1:0]  sum_o,
  output logic                 carry_o
);

  logic [CSUM_LEN:0] raw;

  assign raw     = {1'b0, base_i} + (CSUM_LEN+1)'(field_i);
  assign carry_o = raw[CSUM_LEN];

`ifdef POS_CORE_SAT_EN
  assign sum_o = carry_o ? '1 : raw[CSUM_LEN-1:0];
`else
  assign sum_o = raw[CSUM_LEN-1:0];
`endif

endmodule

// File: rtl/pos_core_nd.sv
// pos_core_nd: DIMS-dimensional position-sum stage of the KNN datapath.
// Splits each label into DIMS equal fields and adds each field to a
// per-dimension sum, either the sums handed in from the previous stage
// (chain mode) or an internal accumulator over a burst (accumulate mode).
// Build option: POS_CORE_SAT_EN (saturating sums, see pos_lane).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   inValid   : input beat valid
//   inL       : label, field 0 in the MSBs
//   inPrev    : previous sums, dimension 0 in the MSBs
//   inMode    : 0 = chain, 1 = accumulate (sampled with inValid)
//   inLast    : final beat of an accumulate burst
//   outValid  : one-cycle pulse with each new result
//   outSum    : result sums, packed like inPrev
//   outOvf    : result overflowed in at least one dimension
module pos_core_nd
  import pos_pkg::*;
#(
  parameter int unsigned LBL_LEN  = 10,
  parameter int unsigned DIMS     = 2,
  parameter int unsigned CSUM_LEN = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inValid,
  input  logic [LBL_LEN-1:0]       inL,
  input  logic [DIMS*CSUM_LEN-1:0] inPrev,
  input  logic                     inMode,
  input  logic                     inLast,
  output logic                     outValid,
  output logic [DIMS*CSUM_LEN-1:0] outSum,
  output logic                     outOvf
);

  localparam int unsigned FIELD_LEN = LBL_LEN / DIMS;
  localparam int unsigned SUM_W     = DIMS * CSUM_LEN;

  pos_state_e       state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic [SUM_W-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [SUM_W-1:0] lane_sum;
  logic [DIMS-1:0]  lane_carry;
  logic             use_acc;
  logic             upd_ovf;

  // Only an accumulate beat in the middle of a burst adds to the
  // accumulator; chain beats and burst-opening beats start from inPrev.
  assign use_acc = (inMode == POS_MODE_ACC) && (state_q == POS_ACC);

  for (genvar d = 0; d < DIMS; d++) begin : g_lane
    localparam int unsigned HI = (DIMS - d) * CSUM_LEN - 1;
    logic [FIELD_LEN-1:0] field;
    logic [CSUM_LEN-1:0]  base;

    assign field = FIELD_LEN'(pos_field(POS_MAX_W'(inL), LBL_LEN, FIELD_LEN, d));
    assign base  = use_acc ? acc_q[HI -: CSUM_LEN] : inPrev[HI -: CSUM_LEN];

    pos_lane #(
      .CSUM_LEN (CSUM_LEN),
      .FIELD_LEN(FIELD_LEN)
    ) u_lane (
      .base_i (base),
      .field_i(field),
      .sum_o  (lane_sum[HI -: CSUM_LEN]),
      .carry_o(lane_carry[d])
    );
  end

  // Sticky burst overflow including this beat's carries.
  assign upd_ovf = (use_acc & acc_ovf_q) | (|lane_carry);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    acc_ovf_d   = acc_ovf_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = 1'b0;

    if (inValid) begin
      if (inMode == POS_MODE_CHAIN) begin
        // Burst state is left alone so a pending burst resumes afterwards.
        out_sum_d   = lane_sum;
        out_ovf_d   = |lane_carry;
        out_valid_d = 1'b1;
      end else if (inLast) begin
        out_sum_d   = lane_sum;
        out_ovf_d   = upd_ovf;
        out_valid_d = 1'b1;
        state_d     = POS_IDLE;
        acc_d       = '0;
        acc_ovf_d   = 1'b0;
      end else begin
        acc_d       = lane_sum;
        acc_ovf_d   = upd_ovf;
        state_d     = POS_ACC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= POS_IDLE;
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      acc_ovf_q   <= acc_ovf_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign outValid = out_valid_q;
  assign outSum   = out_sum_q;
  assign outOvf   = out_ovf_q;

endmodule

// File: tb/tb_pos_core_nd.sv
// Testbench for pos_core_nd at default parameters (two 5-bit fields,
// 7-bit sums). Directed scenarios check spec values; a random phase checks
// against an arithmetic reference model of the chain/burst rules.
module tb_pos_core_nd;

  localparam int SMAX = 127;
`ifdef POS_CORE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, inValid, inMode, inLast;
  logic [9:0]  inL;
  logic [13:0] inPrev;
  logic        outValid;
  logic [13:0] outSum;
  logic        outOvf;

  always #5 clk = ~clk;

  pos_core_nd #(
    .LBL_LEN (10),
    .DIMS    (2),
    .CSUM_LEN(7)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .inValid (inValid),
    .inL     (inL),
    .inPrev  (inPrev),
    .inMode  (inMode),
    .inLast  (inLast),
    .outValid(outValid),
    .outSum  (outSum),
    .outOvf  (outOvf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit m_burst, m_acc_ovf;
  int m_acc[2];
  bit exp_valid, exp_ovf;
  int exp_sum[2];

  function automatic int fit_sum(int s);
    if (s > SMAX) return SAT ? SMAX : s - (SMAX + 1);
    return s;
  endfunction

  // Drives one cycle of inputs, advances the model, and returns #1 after
  // the edge so outputs can be sampled.
  task automatic step(bit r, bit v, bit m, bit l, int fx, int fy, int px, int py);
    int f[2];
    int p[2];
    int nxt[2];
    bit c;
    f = '{fx, fy};
    p = '{px, py};
    rst = r; inValid = v; inMode = m; inLast = l;
    inL = 10'(fx * 32 + fy);
    inPrev = 14'(px * 128 + py);
    @(posedge clk);
    if (r) begin
      m_burst = 0; m_acc_ovf = 0; m_acc = '{0, 0};
      exp_valid = 0; exp_ovf = 0; exp_sum = '{0, 0};
    end else if (!v) begin
      exp_valid = 0;
    end else begin
      c = 0;
      for (int d = 0; d < 2; d++) begin
        int s;
        s = ((m && m_burst) ? m_acc[d] : p[d]) + f[d];
        if (s > SMAX) c = 1;
        nxt[d] = fit_sum(s);
      end
      if (!m) begin
        exp_sum = nxt; exp_ovf = c; exp_valid = 1;
      end else begin
        c = c | (m_burst & m_acc_ovf);
        if (l) begin
          exp_sum = nxt; exp_ovf = c; exp_valid = 1;
          m_burst = 0; m_acc = '{0, 0}; m_acc_ovf = 0;
        end else begin
          m_acc = nxt; m_acc_ovf = c; m_burst = 1; exp_valid = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    // Reset wins over a valid beat in the same cycle.
    step(1, 1, 0, 0, 31, 31, 127, 127);
    n_checks++;
    if (outValid !== 1'b0 || outSum !== 14'd0 || outOvf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b sum=%h ovf=%0b, expected 0/0/0", outValid, outSum, outOvf);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_chain();
    step(0, 1, 0, 0, 3, 5, 10, 20);
    n_checks++;
    if (outValid !== 1'b1) begin
      n_fail++; $display("FAIL chain_valid: got %0b expected 1", outValid);
    end
    n_checks++;
    if (outSum !== {7'd13, 7'd25} || outOvf !== 1'b0) begin
      n_fail++; $display("FAIL chain_sum: got sum=(%0d,%0d) ovf=%0b expected (13,25) ovf=0",
                         outSum[13:7], outSum[6:0], outOvf);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (outValid !== 1'b0) begin
      n_fail++; $display("FAIL chain_pulse: got %0b expected 0", outValid);
    end
  endtask

  task automatic test_overflow();
    logic [6:0] xe;
    xe = SAT ? 7'd127 : 7'd23;
    step(0, 1, 0, 0, 31, 0, 120, 0);
    n_checks++;
    if (outSum !== {xe, 7'd0} || outOvf !== 1'b1 || outValid !== 1'b1) begin
      n_fail++; $display("FAIL overflow: got sum=(%0d,%0d) ovf=%0b v=%0b expected (%0d,0) ovf=1 v=1",
                         outSum[13:7], outSum[6:0], outOvf, outValid, xe);
    end
    // Exactly reaching the top value is not an overflow.
    step(0, 1, 0, 0, 31, 0, 96, 0);
    n_checks++;
    if (outSum !== {7'd127, 7'd0} || outOvf !== 1'b0) begin
      n_fail++; $display("FAIL overflow_edge: got sum=(%0d,%0d) ovf=%0b expected (127,0) ovf=0",
                         outSum[13:7], outSum[6:0], outOvf);
    end
  endtask

  task automatic test_burst();
    step(0, 1, 1, 0, 1, 2, 0, 0);
    n_checks++;
    if (outValid !== 1'b0) begin
      n_fail++; $display("FAIL burst_beat1_valid: got %0b expected 0", outValid);
    end
    step(0, 1, 1, 0, 3, 4, 99, 99);
    n_checks++;
    if (outValid !== 1'b0) begin
      n_fail++; $display("FAIL burst_beat2_valid: got %0b expected 0", outValid);
    end
    step(0, 1, 1, 1, 5, 6, 55, 55);
    n_checks++;
    if (outValid !== 1'b1 || outSum !== {7'd9, 7'd12} || outOvf !== 1'b0) begin
      n_fail++; $display("FAIL burst_result: got v=%0b sum=(%0d,%0d) ovf=%0b expected v=1 (9,12) ovf=0",
                         outValid, outSum[13:7], outSum[6:0], outOvf);
    end
  endtask

  task automatic test_chain_in_burst();
    step(0, 1, 1, 0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 2, 2, 7, 7);
    n_checks++;
    if (outValid !== 1'b1 || outSum !== {7'd9, 7'd9}) begin
      n_fail++; $display("FAIL interleave_chain: got v=%0b sum=(%0d,%0d) expected v=1 (9,9)",
                         outValid, outSum[13:7], outSum[6:0]);
    end
    step(0, 1, 1, 1, 1, 1, 40, 40);
    n_checks++;
    if (outValid !== 1'b1 || outSum !== {7'd2, 7'd2}) begin
      n_fail++; $display("FAIL interleave_burst: got v=%0b sum=(%0d,%0d) expected v=1 (2,2)",
                         outValid, outSum[13:7], outSum[6:0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    step(0, 1, 1, 0, 4, 4, 0, 0);
    step(0, 1, 1, 0, 4, 4, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (outValid !== 1'b0 || outSum !== 14'd0) begin
      n_fail++; $display("FAIL midburst_reset: got v=%0b sum=%h expected v=0 sum=0", outValid, outSum);
    end
    step(0, 1, 1, 1, 1, 1, 0, 0);
    n_checks++;
    if (outValid !== 1'b1 || outSum !== {7'd1, 7'd1} || outOvf !== 1'b0) begin
      n_fail++; $display("FAIL midburst_after: got v=%0b sum=(%0d,%0d) ovf=%0b expected v=1 (1,1) ovf=0",
                         outValid, outSum[13:7], outSum[6:0], outOvf);
    end
  endtask

  task automatic test_sticky_ovf();
    logic [6:0] xe;
    xe = SAT ? 7'd127 : 7'd23;
    step(0, 1, 1, 0, 31, 0, 120, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0);
    n_checks++;
    if (outValid !== 1'b1 || outSum !== {xe, 7'd0} || outOvf !== 1'b1) begin
      n_fail++; $display("FAIL sticky_ovf: got v=%0b sum=(%0d,%0d) ovf=%0b expected v=1 (%0d,0) ovf=1",
                         outValid, outSum[13:7], outSum[6:0], outOvf, xe);
    end
  endtask

  task automatic test_bubbles();
    step(0, 1, 0, 0, 2, 3, 5, 5);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), 9, 9, 9, 9);
      n_checks++;
      if (outValid !== 1'b0 || outSum !== {7'd7, 7'd8}) begin
        n_fail++; $display("FAIL bubble_%0d: got v=%0b sum=(%0d,%0d) expected v=0 (7,8)",
                           i, outValid, outSum[13:7], outSum[6:0]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit r, v, m, l;
      int px, py;
      r  = ($urandom_range(0, 49) == 0);
      v  = ($urandom_range(0, 3) != 0);
      m  = $urandom_range(0, 1);
      l  = ($urandom_range(0, 2) == 0);
      px = $urandom_range(0, 1) ? $urandom_range(96, 127) : $urandom_range(0, 127);
      py = $urandom_range(0, 127);
      step(r, v, m, l, $urandom_range(0, 31), $urandom_range(0, 31), px, py);
      n_checks++;
      if (outValid !== exp_valid || outOvf !== exp_ovf ||
          outSum !== 14'(exp_sum[0] * 128 + exp_sum[1])) begin
        n_fail++;
        $display("FAIL random_%0d: got v=%0b sum=(%0d,%0d) ovf=%0b expected v=%0b (%0d,%0d) ovf=%0b",
                 i, outValid, outSum[13:7], outSum[6:0], outOvf,
                 exp_valid, exp_sum[0], exp_sum[1], exp_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_chain();
    test_overflow();
    test_burst();
    test_chain_in_burst();
    test_reset_mid_burst();
    test_sticky_ovf();
    test_bubbles();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
